// File: rtl/int_seq_ctrl.sv
// Interrupt sequencer: prioritised, nestable interrupt entry/return with
// pipeline-register save/restore strobes and fetch redirection.
module int_seq_ctrl #(
    parameter int              NUM_SRC    = 4,
    parameter int              NEST_DEPTH = 4,
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] VEC_BASE   = 'h100,
    parameter logic [PC_W-1:0] VEC_STRIDE = 'h10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SRC-1:0]                int_req,
    input  logic [NUM_SRC-1:0]                int_mask,
    input  logic                              eret,
    input  logic                              stall,
    input  logic [PC_W-1:0]                   cur_pc,
    output logic                              gre_write_enable,
    output logic                              gre_flush,
    output logic                              gre_save_out,
    output logic                              gre_upper_int,
    output logic                              gre_load_out,
    output logic                              redirect_valid,
    output logic [PC_W-1:0]                   redirect_pc,
    output logic [NUM_SRC-1:0]                int_ack,
    output logic [$clog2(NEST_DEPTH+1)-1:0]   depth,
    output logic                              spurious_eret,
    output logic [2:0]                        dbg_state
);

    localparam int DW = $clog2(NEST_DEPTH + 1);
    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int SW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        SAVE     = 3'd2,
        DISPATCH = 3'd3,
        RET      = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [PC_W-1:0]   pc_stack  [NEST_DEPTH];
    logic [IW-1:0]     lvl_stack [NEST_DEPTH];
    logic [IW-1:0]     sel_idx;
    logic              spur_q;

    logic [SW-1:0]     top_ptr;
    logic [SW-1:0]     push_ptr;
    logic [IW-1:0]     top_lvl;
    logic              elig_any;
    logic [IW-1:0]     elig_idx;

    assign top_ptr   = SW'(depth - DW'(1));
    assign push_ptr  = SW'(depth);
    assign top_lvl   = lvl_stack[top_ptr];
    assign dbg_state = state;

    // Lowest-index unmasked request that outranks the level currently in service.
    always_comb begin
        elig_any = 1'b0;
        elig_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (int_req[i] && !int_mask[i] && (depth == '0 || IW'(i) < top_lvl)) begin
                elig_any = 1'b1;
                elig_idx = IW'(i);
            end
        end
        if (depth >= DW'(NEST_DEPTH)) begin
            elig_any = 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        if (!stall) begin
            case (state)
                IDLE, RUN: begin
                    if (eret) begin
                        state_n = (state == RUN) ? RET : IDLE;
                    end else if (elig_any) begin
                        state_n = SAVE;
                    end
                end
                SAVE:     state_n = DISPATCH;
                DISPATCH: state_n = RUN;
                RET:      state_n = (depth == DW'(1)) ? IDLE : RUN;
                default:  state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            depth   <= '0;
            sel_idx <= '0;
            spur_q  <= 1'b0;
            for (int k = 0; k < NEST_DEPTH; k++) begin
                pc_stack[k]  <= '0;
                lvl_stack[k] <= '0;
            end
        end else begin
            spur_q <= (state == IDLE) && eret && !stall;
            if (!stall) begin
                if ((state == IDLE || state == RUN) && state_n == SAVE) begin
                    sel_idx <= elig_idx;
                end
                if (state == SAVE) begin
                    pc_stack[push_ptr]  <= cur_pc;
                    lvl_stack[push_ptr] <= sel_idx;
                    depth               <= depth + DW'(1);
                end
                if (state == RET) begin
                    depth <= depth - DW'(1);
                end
            end
        end
    end

    // Strobes are pure decodes of state; a stall simply holds them.
    always_comb begin
        gre_flush      = 1'b0;
        gre_save_out   = 1'b0;
        gre_upper_int  = 1'b0;
        gre_load_out   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        int_ack        = '0;
        case (state)
            SAVE: begin
                gre_save_out  = 1'b1;
                gre_upper_int = (depth != '0);
                int_ack       = NUM_SRC'(1) << sel_idx;
            end
            DISPATCH: begin
                redirect_valid = 1'b1;
                redirect_pc    = VEC_BASE + PC_W'(sel_idx) * VEC_STRIDE;
                gre_flush      = 1'b1;
            end
            RET: begin
                redirect_valid = 1'b1;
                redirect_pc    = pc_stack[top_ptr];
                if (depth == DW'(1)) begin
                    gre_load_out = 1'b1;
                end else begin
                    gre_flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign gre_write_enable = rst & ~stall;
    assign spurious_eret    = spur_q;

endmodule
